// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V control unit: Moore sequencer for fetch/decode/execute/memory/writeback
// with cache handshake stalls, illegal-opcode trap and memory-stall watchdog.
module multicycle_control_fsm #(
  parameter bit          ENABLE_JALR    = 1'b1,
  parameter bit          ENABLE_LUI     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic       mem_timeout
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRLINK,
    S_LUI, S_ILLEGAL, S_TIMEOUT
  } state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            waiting;
  logic            funct3_unused;

  assign funct3_unused = ^funct3[2:1];
  assign waiting = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = ENABLE_JALR ? S_JALR : S_ILLEGAL;
          OP_LUI:       state_d = ENABLE_LUI ? S_LUI : S_ILLEGAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JALRLINK;
      S_JALRLINK: state_d = S_FETCH;
      S_LUI:      state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      S_TIMEOUT:  state_d = S_TIMEOUT;
    endcase

    // A completing handshake beats the watchdog; the counter only runs while a wait state holds.
    if (waiting && !mem_ready && (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LIM))
      state_d = S_TIMEOUT;

    cnt_d = '0;
    if (waiting && !mem_ready && (state_d == state_q))
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs follow the state register; the handshake and branch strobes also see live inputs.
  always_comb begin
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = '0;
    alu_src_a     = '0;
    alu_src_b     = '0;
    alu_op        = '0;
    imm_src       = '0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    mem_timeout   = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read   = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src   = 3'b010;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src   = (opcode == OP_SW) ? 3'b001 : 3'b000;
        end
        S_MEMREAD: begin
          mem_read = 1'b1;
          adr_src  = 1'b1;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          mem_write  = 1'b1;
          adr_src    = 1'b1;
          instr_done = mem_ready;
        end
        S_EXECR: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        S_EXECI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b10;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 2'b10;
          alu_op     = 2'b01;
          pc_write   = zero ^ funct3[0];
          instr_done = 1'b1;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        S_JALR: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b01;
          result_src = 2'b10;
          pc_write   = 1'b1;
        end
        S_JALRLINK: begin
          alu_src_a  = 2'b01;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_LUI: begin
          alu_src_a = 2'b11;
          alu_src_b = 2'b01;
          imm_src   = 3'b100;
        end
        S_ILLEGAL: illegal_instr = 1'b1;
        S_TIMEOUT: mem_timeout   = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: vector table, directed corner sequences and
// random traffic against an instruction/step reference model on two parameterisations.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pc_write, adr_src, mem_read, mem_write, ir_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;
    logic       reg_write, instr_done, illegal_instr, mem_timeout;
  } out_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    logic       rdy;
    out_t       exp;
  } vec_t;

  typedef struct {
    int cls;
    int step;
    int cnt;
  } mst_t;

  localparam int C_FETCH = 0, C_DEC = 1, C_LW = 2, C_SW = 3, C_R = 4, C_I = 5,
                 C_BR = 6, C_JAL = 7, C_JALR = 8, C_LUI = 9, C_ILL = 10, C_TO = 11;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  wire [19:0] va, vb;

  int n_chk = 0;
  int n_fail = 0;
  mst_t ma, mb;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.ENABLE_JALR(1'b1), .ENABLE_LUI(1'b1), .TIMEOUT_CYCLES(4), .TO_W(3)) u_a (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .pc_write(va[19]), .adr_src(va[18]), .mem_read(va[17]), .mem_write(va[16]), .ir_write(va[15]),
    .result_src(va[14:13]), .alu_src_a(va[12:11]), .alu_src_b(va[10:9]), .alu_op(va[8:7]),
    .imm_src(va[6:4]), .reg_write(va[3]), .instr_done(va[2]), .illegal_instr(va[1]), .mem_timeout(va[0]));

  multicycle_control_fsm #(.ENABLE_JALR(1'b0), .ENABLE_LUI(1'b0), .TIMEOUT_CYCLES(0), .TO_W(8)) u_b (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .pc_write(vb[19]), .adr_src(vb[18]), .mem_read(vb[17]), .mem_write(vb[16]), .ir_write(vb[15]),
    .result_src(vb[14:13]), .alu_src_a(vb[12:11]), .alu_src_b(vb[10:9]), .alu_op(vb[8:7]),
    .imm_src(vb[6:4]), .reg_write(vb[3]), .instr_done(vb[2]), .illegal_instr(vb[1]), .mem_timeout(vb[0]));

  function automatic out_t o(input logic pcw, input logic adr, input logic mr, input logic mw,
                             input logic irw, input logic [1:0] rs, input logic [1:0] a,
                             input logic [1:0] b, input logic [1:0] op, input logic [2:0] imm,
                             input logic rw, input logic dn, input logic il, input logic to);
    out_t r;
    r = '{pcw, adr, mr, mw, irw, rs, a, b, op, imm, rw, dn, il, to};
    return r;
  endfunction

  // Reference model: instruction class plus step index within that instruction.
  function automatic int decode_cls(input logic [6:0] op, input bit ej, input bit el);
    case (op)
      OP_LW:   return C_LW;
      OP_SW:   return C_SW;
      OP_R:    return C_R;
      OP_I:    return C_I;
      OP_BR:   return C_BR;
      OP_JAL:  return C_JAL;
      OP_JALR: return ej ? C_JALR : C_ILL;
      OP_LUI:  return el ? C_LUI : C_ILL;
      default: return C_ILL;
    endcase
  endfunction

  function automatic int last_step(input int cls);
    if (cls == C_LW) return 3;
    if (cls == C_BR) return 1;
    return 2;
  endfunction

  function automatic bit is_wait(input mst_t s);
    return (s.cls == C_FETCH) || ((s.cls == C_LW || s.cls == C_SW) && s.step == 2);
  endfunction

  function automatic mst_t advance(input mst_t s, input logic [6:0] op, input bit ej, input bit el);
    mst_t n = s;
    n.cnt = 0;
    if (s.cls == C_FETCH) begin
      n.cls = C_DEC; n.step = 0;
    end else if (s.cls == C_DEC) begin
      n.cls = decode_cls(op, ej, el); n.step = 1;
    end else if (s.step >= last_step(s.cls)) begin
      n.cls = C_FETCH; n.step = 0;
    end else begin
      n.step = s.step + 1;
    end
    return n;
  endfunction

  function automatic mst_t mstep(input mst_t s, input logic r, input logic [6:0] op, input logic rdy,
                                 input bit ej, input bit el, input int to);
    mst_t n = s;
    if (r) begin
      n.cls = C_FETCH; n.step = 0; n.cnt = 0;
    end else if (s.cls == C_ILL || s.cls == C_TO) begin
      n = s;
    end else if (is_wait(s)) begin
      if (rdy) n = advance(s, op, ej, el);
      else if (to != 0 && s.cnt == to) begin
        n.cls = C_TO; n.cnt = 0;
      end else n.cnt = s.cnt + 1;
    end else begin
      n = advance(s, op, ej, el);
    end
    return n;
  endfunction

  function automatic out_t mexp(input mst_t s, input logic r, input logic [2:0] f3, input logic z,
                                input logic rdy);
    out_t e = '0;
    if (r) return e;
    case (s.cls)
      C_FETCH: begin
        e.mem_read = 1'b1; e.alu_src_b = 2'd2; e.result_src = 2'd2;
        e.ir_write = rdy; e.pc_write = rdy;
      end
      C_DEC: begin e.alu_src_a = 2'd1; e.alu_src_b = 2'd1; e.imm_src = 3'd2; end
      C_LW, C_SW: begin
        if (s.step == 1) begin
          e.alu_src_a = 2'd2; e.alu_src_b = 2'd1; e.imm_src = (s.cls == C_SW) ? 3'd1 : 3'd0;
        end else if (s.step == 2) begin
          e.adr_src = 1'b1;
          if (s.cls == C_LW) e.mem_read = 1'b1;
          else begin e.mem_write = 1'b1; e.instr_done = rdy; end
        end else begin
          e.result_src = 2'd1; e.reg_write = 1'b1; e.instr_done = 1'b1;
        end
      end
      C_R, C_I, C_JAL, C_LUI: begin
        if (s.step == 2) begin
          e.reg_write = 1'b1; e.instr_done = 1'b1;
        end else if (s.cls == C_R) begin
          e.alu_src_a = 2'd2; e.alu_op = 2'd2;
        end else if (s.cls == C_I) begin
          e.alu_src_a = 2'd2; e.alu_src_b = 2'd1; e.alu_op = 2'd2;
        end else if (s.cls == C_JAL) begin
          e.alu_src_a = 2'd1; e.alu_src_b = 2'd2; e.pc_write = 1'b1;
        end else begin
          e.alu_src_a = 2'd3; e.alu_src_b = 2'd1; e.imm_src = 3'd4;
        end
      end
      C_BR: begin
        e.alu_src_a = 2'd2; e.alu_op = 2'd1; e.pc_write = z ^ f3[0]; e.instr_done = 1'b1;
      end
      C_JALR: begin
        if (s.step == 1) begin
          e.alu_src_a = 2'd2; e.alu_src_b = 2'd1; e.result_src = 2'd2; e.pc_write = 1'b1;
        end else begin
          e.alu_src_a = 2'd1; e.alu_src_b = 2'd2; e.result_src = 2'd2;
          e.reg_write = 1'b1; e.instr_done = 1'b1;
        end
      end
      C_ILL: e.illegal_instr = 1'b1;
      C_TO:  e.mem_timeout = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [19:0] got, input logic [19:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [6:0] op, input logic [2:0] f3, input logic z,
                     input logic rdy);
    @(negedge clk);
    rst = r; opcode = op; funct3 = f3; zero = z; mem_ready = rdy;
    #1;
    chk("modelA", va, mexp(ma, r, f3, z, rdy));
    chk("modelB", vb, mexp(mb, r, f3, z, rdy));
    ma = mstep(ma, r, op, rdy, 1'b1, 1'b1, 4);
    mb = mstep(mb, r, op, rdy, 1'b0, 1'b0, 0);
  endtask

  vec_t       tbl[16];
  logic [6:0] ops[11];
  logic [6:0] cur_op;
  out_t       f0, fr, dec, bt, bn;

  initial begin
    ma = '{C_FETCH, 0, 0};
    mb = '{C_FETCH, 0, 0};
    f0  = o(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    fr  = o(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 2'd0, 2'd2, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    dec = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 2'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    bt  = o(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 2'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    bn  = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 2'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[0]  = '{1'b1, OP_LW, 3'd0, 1'b0, 1'b0, out_t'('0)};
    tbl[1]  = '{1'b0, OP_LW, 3'd0, 1'b0, 1'b1, fr};
    tbl[2]  = '{1'b0, OP_LW, 3'd0, 1'b0, 1'b1, dec};
    tbl[3]  = '{1'b0, OP_LW, 3'd0, 1'b0, 1'b1,
                o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
    for (int i = 4; i < 8; i++)
      tbl[i] = '{1'b0, OP_LW, 3'd0, 1'b0, (i == 7),
                 o(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[8]  = '{1'b0, OP_LW, 3'd0, 1'b0, 1'b1,
                o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[9]  = '{1'b0, OP_BR, 3'd0, 1'b1, 1'b0, f0};
    tbl[10] = '{1'b0, OP_BR, 3'd0, 1'b1, 1'b1, fr};
    tbl[11] = '{1'b0, OP_BR, 3'd0, 1'b1, 1'b1, dec};
    tbl[12] = '{1'b0, OP_BR, 3'd0, 1'b1, 1'b1, bt};
    tbl[13] = '{1'b0, OP_BR, 3'd1, 1'b1, 1'b1, fr};
    tbl[14] = '{1'b0, OP_BR, 3'd1, 1'b1, 1'b1, dec};
    tbl[15] = '{1'b0, OP_BR, 3'd1, 1'b1, 1'b1, bn};

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].rst, tbl[i].op, tbl[i].f3, tbl[i].z, tbl[i].rdy);
      chk($sformatf("vec%0d", i), va, tbl[i].exp);
    end

    // jalr: taken on A, trapped on B (jalr disabled)
    cyc(1'b1, OP_JALR, 3'd0, 1'b0, 1'b1);
    cyc(1'b0, OP_JALR, 3'd0, 1'b0, 1'b1);
    cyc(1'b0, OP_JALR, 3'd0, 1'b0, 1'b1);
    cyc(1'b0, OP_JALR, 3'd0, 1'b0, 1'b1);
    chk("jalr_pcw", 20'(va[19]), 20'd1);
    chk("jalr_rsrc", 20'(va[14:13]), 20'd2);
    chk("nojalr_ill", 20'(vb[1]), 20'd1);
    cyc(1'b0, OP_JALR, 3'd0, 1'b0, 1'b1);
    chk("link_rw", 20'(va[3]), 20'd1);
    chk("link_ab", 20'(va[12:9]), 20'b0110);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, OP_R, 3'd0, 1'b0, 1'b1);
      chk("nojalr_hold", 20'({vb[17], vb[1]}), 20'b01);
    end

    // lui then ALUWB; illegal opcode held until reset
    cyc(1'b1, OP_LUI, 3'd0, 1'b0, 1'b1);
    cyc(1'b0, OP_LUI, 3'd0, 1'b0, 1'b1);
    cyc(1'b0, OP_LUI, 3'd0, 1'b0, 1'b1);
    cyc(1'b0, OP_LUI, 3'd0, 1'b0, 1'b1);
    chk("lui_a", 20'(va[12:11]), 20'd3);
    chk("lui_imm", 20'(va[6:4]), 20'd4);
    cyc(1'b0, OP_LUI, 3'd0, 1'b0, 1'b1);
    chk("lui_wb", 20'(va[3]), 20'd1);
    cyc(1'b0, OP_BAD, 3'd0, 1'b0, 1'b1);
    cyc(1'b0, OP_BAD, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, OP_BAD, 3'd0, 1'b0, 1'b1);
      chk("ill_hold", 20'({va[17], va[1]}), 20'b01);
    end
    cyc(1'b1, OP_LW, 3'd0, 1'b0, 1'b1);
    cyc(1'b0, OP_LW, 3'd0, 1'b0, 1'b0);
    chk("ill_clear", 20'({va[17], va[1]}), 20'b10);

    // watchdog: 5 stalled FETCH cycles trip it; ready on the 5th wins
    cyc(1'b1, OP_LW, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, OP_LW, 3'd0, 1'b0, 1'b0);
      chk("to_pre", 20'({va[17], va[0]}), 20'b10);
    end
    cyc(1'b0, OP_LW, 3'd0, 1'b0, 1'b0);
    chk("to_hit", 20'({va[17], va[0]}), 20'b01);
    cyc(1'b0, OP_LW, 3'd0, 1'b0, 1'b1);
    chk("to_hold", 20'({va[17], va[0]}), 20'b01);
    cyc(1'b1, OP_LW, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, OP_LW, 3'd0, 1'b0, (i == 4));
    cyc(1'b0, OP_LW, 3'd0, 1'b0, 1'b0);
    chk("to_miss", 20'({va[12:11], va[0]}), 20'b010);

    // reset during MEMWRITE wait
    cyc(1'b1, OP_SW, 3'd0, 1'b0, 1'b1);
    cyc(1'b0, OP_SW, 3'd0, 1'b0, 1'b1);
    cyc(1'b0, OP_SW, 3'd0, 1'b0, 1'b1);
    cyc(1'b0, OP_SW, 3'd0, 1'b0, 1'b1);
    chk("sw_imm", 20'(va[6:4]), 20'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, OP_SW, 3'd0, 1'b0, 1'b0);
    chk("sw_wait", 20'({va[16], va[18], va[2]}), 20'b110);
    cyc(1'b1, OP_SW, 3'd0, 1'b0, 1'b0);
    chk("sw_rst", va, 20'd0);
    cyc(1'b0, OP_SW, 3'd0, 1'b0, 1'b0);
    chk("sw_refetch", 20'({va[17], va[16], va[1:0]}), 20'b1000);

    // random traffic against the model
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_BAD, 7'd0, 7'd0};
    cur_op = OP_LW;
    for (int i = 0; i < 3000; i++) begin
      logic r;
      r = ($urandom_range(0, 199) == 0);
      if (ma.cls == C_ILL || ma.cls == C_TO || mb.cls == C_ILL || mb.cls == C_TO)
        r = ($urandom_range(0, 3) == 0);
      if (ma.cls == C_FETCH) begin
        ops[10] = 7'($urandom);
        cur_op = ops[$urandom_range(0, 10)];
      end
      cyc(r, cur_op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
